muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle controller for the HI/LO unit beside the EXE-stage ALU. Accepts MULT/MULTU/DIV/DIVU
//   issued from EXE, runs an iterative shift-add multiply or restoring divide, and writes HI/LO.
//   It also services MTHI/MTLO writes and MFHI/MFLO reads.
//   Raises stall to freeze IF/ID/EXE while a HI/LO consumer or a second muldiv waits on a running op.
// PARAMETERS
//   WIDTH    32   operand width; HI/LO are WIDTH each, internal product/remainder 2*WIDTH
// PORTS
//   CLK        in   1      clock, rising edge
//   RESET      in   1      asynchronous reset, active-high
//   start      in   1      EXE holds a mul/div instruction this cycle
//   op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Operand_A  in   WIDTH  rs value (forwarded)
//   Operand_B  in   WIDTH  rt value (forwarded)
//   hilo_rd    in   1      EXE holds MFHI/MFLO this cycle
//   mthi       in   1      EXE holds MTHI; writes Operand_A into HI
//   mtlo       in   1      EXE holds MTLO; writes Operand_A into LO
//   flush      in   1      pipeline flush; abort any running op
//   HI         out  WIDTH  HI register
//   LO         out  WIDTH  LO register
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse on the edge HI/LO receive a muldiv result
//   stall      out  1      freeze upstream stages
// BEHAVIOUR
//   Reset (RESET=1, async): state=IDLE, HI=LO=0, count=0, done=0, busy=0, stall=0, internal regs=0.
//     Reset mid-operation discards the op; no partial HI/LO write.
//   FSM states:
//     IDLE -start&!flush-> MUL (op[1]=0) or DIV (op[1]=1).
//     MUL/DIV: WIDTH iterations; count 0..WIDTH-1; at count==WIDTH-1 -> FIX.
//     FIX: applies sign correction, writes HI/LO, pulses done -> IDLE.
//     flush in any non-IDLE state -> IDLE next edge; HI/LO unchanged; done stays 0.
//   Start capture:
//     Operands are latched on the accepting edge.
//     Signed ops (op[0]=0) latch magnitudes plus signs sA=A[msb], sB=B[msb].
//     Unsigned ops latch raw values.
//   Latency: start sampled at edge E0 -> done high and HI/LO valid after edge E0+WIDTH+1
//     (WIDTH iterate cycles + 1 FIX). 34 cycles for WIDTH=32.
//   MUL: 64-bit product; LO=product[WIDTH-1:0], HI=product[2W-1:W].
//     Signed: negate the full 2W product when sA^sB.
//   DIV: LO=quotient, HI=remainder.
//     Signed: quotient negated when sA^sB; remainder takes sign sA.
//     Divide by zero is not trapped:
//       unsigned: LO={WIDTH{1}}, HI=A.
//       signed: magnitude rules above apply to the raw result (LO=all-ones pre-sign).
//   Signed overflow: MIN_INT/-1 -> LO=MIN_INT, HI=0 (wrap).
//   MTHI/MTLO:
//     In IDLE, write on the next edge.
//     While busy, they stall until IDLE, then write; a concurrent FIX write is overwritten by them.
//   Stall, combinational: stall = busy & (start | hilo_rd | mthi | mtlo).
//     A start while busy is not accepted; it is re-presented by the frozen pipeline.
//     stall is 0 in the FIX cycle for hilo_rd only if the FIX-bypass is used: HI/LO outputs are
//     registers, so hilo_rd stalls through FIX and reads in the following IDLE cycle.
//   start and mthi/mtlo together in IDLE: start is accepted, mthi/mtlo write takes effect that edge.
//   flush and start in the same IDLE cycle: start is ignored.
//   HI/LO change only on FIX, mthi/mtlo write, or reset.
// TESTING
//   MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 34 cycles done=1, HI=0xFFFFFFFE, LO=0x00000001.
//   MULT A=-3 (0xFFFFFFFD) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//   DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//   DIVU A=5 B=0 -> LO=0xFFFFFFFF, HI=5.
//   During a running op, hilo_rd=1 -> stall=1 every cycle until IDLE.
//   A second start mid-op -> stall=1 and no re-capture.
//   flush at iteration 10 -> IDLE next edge, HI/LO keep prior values, done never pulses.
//   RESET asserted at iteration 20 -> HI=LO=0 and busy=0 immediately.
//   mthi A=0x1234 in IDLE -> HI=0x1234 next edge, stall=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: shift-add MULT/MULTU, restoring DIV/DIVU; result and done land WIDTH+1 edges after the accepting edge.
// No start is accepted while busy; stall holds upstream while a start or HI/LO access meets a running op.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             hilo_rd,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_is_div;
    logic                 r_sa;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_cnt_last;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [2*WIDTH-1:0]   w_div_acc;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_accept   = (r_state == S_IDLE) & start & ~flush;
    assign w_signed   = ~op[0];
    assign w_sa       = w_signed & Operand_A[WIDTH-1];
    assign w_sb       = w_signed & Operand_B[WIDTH-1];
    assign w_mag_a    = w_sa ? -Operand_A : Operand_A;
    assign w_mag_b    = w_sb ? -Operand_B : Operand_B;
    assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

    // Multiply: {HI-half, LO-half} holds {partial sum, unconsumed multiplier bits}.
    assign w_addend  = r_acc[0] ? r_b : {WIDTH{1'b0}};
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at bit 0.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_acc = {(w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sa  ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_next = op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (flush) w_next = S_IDLE;
                          else if (w_cnt_last) w_next = S_FIX;
            S_FIX:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        stall = busy & (start | hilo_rd | mthi | mtlo);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_b      <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                        r_is_div <= op[1];
                        r_sa     <= w_sa;
                        r_neg    <= w_sa ^ w_sb;
                    end
                    if (mthi) r_hi <= Operand_A;
                    if (mtlo) r_lo <= Operand_A;
                end
                S_MUL: if (!flush) begin
                    r_acc <= w_mul_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: if (!flush) begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: if (!flush) begin
                    r_hi   <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                    r_lo   <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign done = r_done;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [1:0]  op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        hilo_rd;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        stall;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op),
        .Operand_A(Operand_A), .Operand_B(Operand_B),
        .hilo_rd(hilo_rd), .mthi(mthi), .mtlo(mtlo), .flush(flush),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .stall(stall)
    );

    always #5 CLK = ~CLK;

    // Returns {HI, LO} from plain integer arithmetic on the architectural operands.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sb; res = p; end
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) res = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges (after the accepting edge) until done is seen; capped at 40.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n;
        e = ref_model(o, a, b);
        @(negedge CLK);
        start = 1'b1; op = o; Operand_A = a; Operand_B = b;
        @(negedge CLK);
        start = 1'b0; Operand_A = $urandom; Operand_B = $urandom;
        check({tag, "_busy"}, busy, 1);
        wait_done(n);
        check({tag, "_latency"}, n, 34);
        check({tag, "_hi"}, HI, e[63:32]);
        check({tag, "_lo"}, LO, e[31:0]);
    endtask

    initial begin
        logic [63:0] e, e_keep;
        logic [31:0] a, b;
        logic [1:0]  o;
        int          n;
        bit          seen_done;

        RESET = 1'b1; start = 1'b0; op = 2'd0; Operand_A = '0; Operand_B = '0;
        hilo_rd = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        #2;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 2'd3, 32'd5, 32'd0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF9, 32'd0);
        run_op("div_neg_b", 2'd2, 32'd100, 32'hFFFF_FFF9);

        // MFHI/MFLO held during a running op stalls every cycle through FIX.
        e = ref_model(2'd1, 32'd12345, 32'd6789);
        @(negedge CLK);
        start = 1'b1; op = 2'd1; Operand_A = 32'd12345; Operand_B = 32'd6789;
        @(negedge CLK);
        start = 1'b0; hilo_rd = 1'b1;
        n = 1;
        #1 check("rd_stall", stall, 1);
        while (done !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
            #1;
            if (done !== 1'b1) check("rd_stall", stall, 1);
        end
        check("rd_latency", n, 34);
        check("rd_stall_idle", stall, 0);
        check("rd_lo", LO, e[31:0]);
        hilo_rd = 1'b0;

        // A second start while busy stalls and does not re-capture operands.
        e = ref_model(2'd3, 32'd100, 32'd7);
        @(negedge CLK);
        start = 1'b1; op = 2'd3; Operand_A = 32'd100; Operand_B = 32'd7;
        @(negedge CLK);
        op = 2'd1; Operand_A = 32'hDEAD_BEEF; Operand_B = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            #1 check("restart_stall", stall, 1);
            @(negedge CLK);
        end
        start = 1'b0;
        wait_done(n);
        check("restart_hi", HI, e[63:32]);
        check("restart_lo", LO, e[31:0]);
        @(negedge CLK);
        check("restart_idle", busy, 0);
        e_keep = e;

        // Flush mid-op: back to IDLE, HI/LO untouched, no done pulse.
        @(negedge CLK);
        start = 1'b1; op = 2'd0; Operand_A = $urandom; Operand_B = $urandom;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge CLK);
        end
        check("flush_no_done", seen_done, 0);
        check("flush_hi", HI, e_keep[63:32]);
        check("flush_lo", LO, e_keep[31:0]);

        // Reset mid-op clears everything immediately.
        @(negedge CLK);
        start = 1'b1; op = 2'd2; Operand_A = $urandom; Operand_B = $urandom;
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        check("arst_busy", busy, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // MTHI/MTLO in IDLE.
        @(negedge CLK);
        mthi = 1'b1; Operand_A = 32'h1234;
        #1 check("mthi_stall", stall, 0);
        @(negedge CLK);
        mthi = 1'b0;
        check("mthi_hi", HI, 32'h1234);
        check("mthi_lo", LO, 0);
        mtlo = 1'b1; Operand_A = 32'h5678;
        @(negedge CLK);
        mtlo = 1'b0;
        check("mtlo_lo", LO, 32'h5678);
        check("mtlo_hi", HI, 32'h1234);

        // start together with MTHI in IDLE: both take effect on the same edge.
        start = 1'b1; mthi = 1'b1; op = 2'd1; Operand_A = 32'd3; Operand_B = 32'd4;
        @(negedge CLK);
        start = 1'b0; mthi = 1'b0;
        check("start_mthi_hi", HI, 32'd3);
        check("start_mthi_busy", busy, 1);
        wait_done(n);
        check("start_mthi_res_hi", HI, 0);
        check("start_mthi_res_lo", LO, 32'd12);

        // MTLO while busy waits for IDLE and then overwrites the fresh result.
        e = ref_model(2'd0, 32'h0001_0003, 32'hFFFF_0005);
        @(negedge CLK);
        start = 1'b1; op = 2'd0; Operand_A = 32'h0001_0003; Operand_B = 32'hFFFF_0005;
        @(negedge CLK);
        start = 1'b0; mtlo = 1'b1; Operand_A = 32'hABCD;
        #1 check("mtlo_busy_stall", stall, 1);
        wait_done(n);
        check("mtlo_busy_res_lo", LO, e[31:0]);
        check("mtlo_busy_idle_stall", stall, 0);
        @(negedge CLK);
        mtlo = 1'b0;
        check("mtlo_busy_lo", LO, 32'hABCD);
        check("mtlo_busy_hi", HI, e[63:32]);

        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("rand", o, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
